tcm_port_arbiter: RTL

//  Shares TCM port 1 (the read/write data port) between two masters: m0 = core load/store unit, m1 = debug/DMA master.

---
 rtl/tcm_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_port_arbiter
//
// Shares TCM port 1 (the read/write data port) between two masters:
//   m0 = core load/store unit (fixed priority)
//   m1 = debug/DMA master (may lock the port across a multi-beat transfer)
// Grants are combinational and single-cycle.  The single outstanding read is
// tracked so that the TCM's registered read data (valid the cycle after the
// read strobe) is steered back to the master that issued it.
//
// Build option:
//   TCM_ARB_STARVE_EN  when defined, an 8-bit wait counter lets m1 win one
//                      grant over m0 after STARVE_LIMIT consecutive lost
//                      cycles.  When undefined, m0 has strict priority.
//
// Parameters:
//   ADDR_W        address width of masters and TCM port
//   DATA_W        data width of masters and TCM port
//   STARVE_LIMIT  m1 wait cycles before a forced grant (1..255)
//
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   mX_req_i/we_i/addr_i/size_i/wdata_i   master X request and payload
//   mX_gnt_o                       master X access accepted this cycle
//   mX_rvalid_o/rdata_o            master X read return (rdata zero if !rvalid)
//   m1_lock_i                      keep port for m1's next beat
//   tcm_addr_o/rd_o/we_o/size_o/wdata_o   to TCM port 1
//   tcm_rdata_i                    registered read data from TCM port 1
// -----------------------------------------------------------------------------
module tcm_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [2:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [2:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] tcm_addr_o,
  output logic              tcm_rd_o,
  output logic              tcm_we_o,
  output logic [2:0]        tcm_size_o,
  output logic [DATA_W-1:0] tcm_wdata_o,
  input  logic [DATA_W-1:0] tcm_rdata_i
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_LOCK1 = 1'b1;

  logic [0:0] state_q, state_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_own_q, rd_own_d;
  logic       starve_win;

`ifdef TCM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  // m1 has waited long enough: it takes the next grant even if m0 requests.
  assign starve_win = m1_req_i && (starve_cnt_q == STARVE_MAX);

  // Count cycles m1 is left waiting, saturating at the limit; any m1 grant
  // or a dropped m1 request restarts the count.
  always_comb begin
    starve_cnt_d = 8'd0;
    if (m1_req_i && !m1_gnt_o) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                  : starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict m0 priority; the limit parameter has no effect in this build.
  assign starve_win = 1'b0 & (STARVE_LIMIT == 0);
`endif

  // Grant selection.  Everything is gated by reset so no access is accepted
  // (and hence no read is ever tracked) while the block is held in reset.
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (rst_n_i) begin
      if (state_q == ST_LOCK1) begin
        m1_gnt_o = m1_req_i;
      end else if (starve_win) begin
        m1_gnt_o = 1'b1;
      end else if (m0_req_i) begin
        m0_gnt_o = 1'b1;
      end else begin
        m1_gnt_o = m1_req_i;
      end
    end
  end

  // Drive the TCM with the winner's payload; idle port is all zero.
  always_comb begin
    tcm_addr_o  = '0;
    tcm_rd_o    = 1'b0;
    tcm_we_o    = 1'b0;
    tcm_size_o  = 3'b000;
    tcm_wdata_o = '0;
    if (m0_gnt_o) begin
      tcm_addr_o  = m0_addr_i;
      tcm_rd_o    = !m0_we_i;
      tcm_we_o    = m0_we_i;
      tcm_size_o  = m0_size_i;
      tcm_wdata_o = m0_wdata_i;
    end else if (m1_gnt_o) begin
      tcm_addr_o  = m1_addr_i;
      tcm_rd_o    = !m1_we_i;
      tcm_we_o    = m1_we_i;
      tcm_size_o  = m1_size_i;
      tcm_wdata_o = m1_wdata_i;
    end
  end

  // Lock tracking: a locked m1 beat holds the port; the lock ends either on
  // an unlocked m1 beat or as soon as m1 stops requesting.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOCK1) begin
      if (!m1_req_i || !m1_lock_i) begin
        state_d = ST_ARB;
      end
    end else begin
      if (m1_gnt_o && m1_lock_i) begin
        state_d = ST_LOCK1;
      end
    end
  end

  // A read strobe this cycle means TCM data arrives next cycle; remember
  // which master it belongs to.
  always_comb begin
    rd_pend_d = tcm_rd_o;
    rd_own_d  = m1_gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_ARB;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  // Read return is also masked during reset so a read accepted just before
  // reset asserts never reports valid data.
  assign m0_rvalid_o = rst_n_i && rd_pend_q && !rd_own_q;
  assign m1_rvalid_o = rst_n_i && rd_pend_q && rd_own_q;
  assign m0_rdata_o  = m0_rvalid_o ? tcm_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? tcm_rdata_i : '0;

endmodule
